// File: rtl/uart_alu_pkg.sv
// Shared widths, ALU opcodes and state encodings for the UART command/response core.
package uart_alu_pkg;

    localparam int NB_DATA     = 8;
    localparam int NB_OPERADOR = 6;

    localparam logic [NB_OPERADOR-1:0] OP_ADD = 6'b100000;
    localparam logic [NB_OPERADOR-1:0] OP_SUB = 6'b100010;
    localparam logic [NB_OPERADOR-1:0] OP_AND = 6'b100100;
    localparam logic [NB_OPERADOR-1:0] OP_OR  = 6'b100101;
    localparam logic [NB_OPERADOR-1:0] OP_XOR = 6'b100110;
    localparam logic [NB_OPERADOR-1:0] OP_NOR = 6'b100111;
    localparam logic [NB_OPERADOR-1:0] OP_SRA = 6'b000011;
    localparam logic [NB_OPERADOR-1:0] OP_SRL = 6'b000010;

    // Which received byte the next rx_done edge delivers
    typedef enum logic [1:0] {
        GET_A  = 2'd0,
        GET_B  = 2'd1,
        GET_OP = 2'd2
    } rx_state_t;

    // Transmit handshake states
    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_WAIT  = 2'd2
    } tx_state_t;

endpackage

// File: rtl/uart_alu_alu_core.sv
// Purely combinational 8-bit ALU; unknown opcodes yield zero.
module alu_core
    import uart_alu_pkg::*;
(
    input  logic [NB_DATA-1:0]     a,
    input  logic [NB_DATA-1:0]     b,
    input  logic [NB_OPERADOR-1:0] op,
    output logic [NB_DATA-1:0]     result
);

    // Opcode decode; shifts use only the low three bits of b
    always_comb begin
        result = '0;
        case (op)
            OP_ADD:  result = a + b;
            OP_SUB:  result = a - b;
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            OP_NOR:  result = ~(a | b);
            OP_SRA:  result = $signed(a) >>> b[2:0];
            OP_SRL:  result = a >> b[2:0];
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/uart_alu_core.sv
// Assembles A, B and opcode bytes from the UART receiver, evaluates them and
// hands the result to the UART transmitter with a start/done handshake.
module uart_alu_core
    import uart_alu_pkg::*;
(
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [NB_DATA-1:0] i_rx_data,
    input  logic               i_rx_done,
    input  logic               i_tx_done,
    output logic [NB_DATA-1:0] o_tx_data,
    output logic               o_tx_start
);

    logic                   rx_done_prev;
    logic                   tx_done_prev;
    logic                   rx_edge;
    logic                   tx_edge;

    rx_state_t              rx_state;
    logic [NB_DATA-1:0]     opnd_a;
    logic [NB_DATA-1:0]     opnd_b;
    logic [NB_OPERADOR-1:0] opcode;
    logic                   alu_valid;

    logic [NB_DATA-1:0]     alu_out;
    logic [NB_DATA-1:0]     result;
    logic                   alu_done;

    tx_state_t              tx_state;
    logic                   pend_valid;
    logic [NB_DATA-1:0]     pend_data;

    assign rx_edge = i_rx_done & ~rx_done_prev;
    assign tx_edge = i_tx_done & ~tx_done_prev;

    // Previous values of the done flags, so held levels count only once
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rx_done_prev <= 1'b0;
            tx_done_prev <= 1'b0;
        end else begin
            rx_done_prev <= i_rx_done;
            tx_done_prev <= i_tx_done;
        end
    end

    // Byte assembler: A, then B, then opcode which fires the ALU
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rx_state  <= GET_A;
            opnd_a    <= '0;
            opnd_b    <= '0;
            opcode    <= '0;
            alu_valid <= 1'b0;
        end else begin
            alu_valid <= 1'b0;
            if (rx_edge) begin
                case (rx_state)
                    GET_A: begin
                        opnd_a   <= i_rx_data;
                        rx_state <= GET_B;
                    end
                    GET_B: begin
                        opnd_b   <= i_rx_data;
                        rx_state <= GET_OP;
                    end
                    GET_OP: begin
                        opcode    <= i_rx_data[NB_OPERADOR-1:0];
                        alu_valid <= 1'b1;
                        rx_state  <= GET_A;
                    end
                    default: rx_state <= GET_A;
                endcase
            end
        end
    end

    alu_core u_alu (
        .a      (opnd_a),
        .b      (opnd_b),
        .op     (opcode),
        .result (alu_out)
    );

    // Result register, held until the next evaluation; done pulses alongside
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            result   <= '0;
            alu_done <= 1'b0;
        end else begin
            alu_done <= alu_valid;
            if (alu_valid) begin
                result <= alu_out;
            end
        end
    end

    // Transmit handshake with a one-entry pending buffer (newest result wins)
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            tx_state   <= TX_IDLE;
            o_tx_data  <= '0;
            o_tx_start <= 1'b0;
            pend_valid <= 1'b0;
            pend_data  <= '0;
        end else begin
            case (tx_state)
                TX_IDLE: begin
                    o_tx_start <= 1'b0;
                    if (alu_done) begin
                        o_tx_data  <= result;
                        pend_valid <= 1'b0;
                        tx_state   <= TX_START;
                    end else if (pend_valid) begin
                        o_tx_data  <= pend_data;
                        pend_valid <= 1'b0;
                        tx_state   <= TX_START;
                    end
                end
                TX_START: begin
                    o_tx_start <= 1'b1;
                    tx_state   <= TX_WAIT;
                    if (alu_done) begin
                        pend_valid <= 1'b1;
                        pend_data  <= result;
                    end
                end
                TX_WAIT: begin
                    o_tx_start <= 1'b0;
                    if (tx_edge) begin
                        tx_state <= TX_IDLE;
                    end
                    if (alu_done) begin
                        pend_valid <= 1'b1;
                        pend_data  <= result;
                    end
                end
                default: begin
                    o_tx_start <= 1'b0;
                    tx_state   <= TX_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_alu_core.sv
// Self-checking bench for uart_alu_core: directed vectors, random triples
// against a behavioural ALU model, back-to-back pending and mid-frame reset.
module tb_uart_alu_core;

    logic       clk;
    logic       rst;
    logic [7:0] rx_data;
    logic       rx_done;
    logic       tx_done;
    logic [7:0] tx_data;
    logic       tx_start;

    int checks;
    int errors;

    logic [7:0] tx_q[$];

    uart_alu_core dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_rx_data  (rx_data),
        .i_rx_done  (rx_done),
        .i_tx_done  (tx_done),
        .o_tx_data  (tx_data),
        .o_tx_start (tx_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every cycle in which a transmit request is visible
    always @(negedge clk) begin
        if (!rst && tx_start) tx_q.push_back(tx_data);
    end

    function automatic logic [7:0] ref_alu(input logic [7:0] a, input logic [7:0] b,
                                           input logic [7:0] opb);
        int op, sh, ia, ib, sv, r;
        op = int'(opb) % 64;
        sh = int'(b) % 8;
        ia = int'(a);
        ib = int'(b);
        case (op)
            32: r = (ia + ib) % 256;
            34: r = (ia - ib + 256) % 256;
            36: r = ia & ib;
            37: r = ia | ib;
            38: r = ia ^ ib;
            39: r = 255 - (ia | ib);
            3: begin
                sv = (ia >= 128) ? ia - 256 : ia;
                r  = (sv >>> sh) & 255;
            end
            2:  r = ia >> sh;
            default: r = 0;
        endcase
        return r[7:0];
    endfunction

    task automatic send_byte(input logic [7:0] d, input int hold);
        @(posedge clk); #1;
        rx_data = d;
        rx_done = 1'b1;
        repeat (hold) @(posedge clk);
        #1 rx_done = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    task automatic send_triple(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op);
        send_byte(a, 1);
        send_byte(b, 1);
        send_byte(op, 1);
    endtask

    task automatic wait_tx(input int n, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            if (tx_q.size() >= n) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic tx_ack();
        @(posedge clk); #1 tx_done = 1'b1;
        repeat (2) @(posedge clk);
        #1 tx_done = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (tx_start !== 1'b0) begin
            errors++; $display("FAIL reset_start got=%0b want=0", tx_start);
        end
        checks++;
        if (tx_data !== 8'h00) begin
            errors++; $display("FAIL reset_data got=%02h want=00", tx_data);
        end
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_directed();
        logic [7:0] va[8], vb[8], vo[8], ve[8];
        bit ok;
        va = '{8'h06, 8'h06, 8'hFF, 8'h03, 8'h80, 8'h80, 8'h0A, 8'h12};
        vb = '{8'h11, 8'h05, 8'h02, 8'h05, 8'h01, 8'h01, 8'h07, 8'h34};
        vo = '{8'h27, 8'h20, 8'h20, 8'h22, 8'h03, 8'h02, 8'hE0, 8'h3F};
        ve = '{8'hE8, 8'h0B, 8'h01, 8'hFE, 8'hC0, 8'h40, 8'h11, 8'h00};
        for (int i = 0; i < 8; i++) begin
            tx_q.delete();
            send_triple(va[i], vb[i], vo[i]);
            wait_tx(1, ok);
            checks++;
            if (!ok) begin
                errors++; $display("FAIL dir%0d_timeout got=%0d starts want=1", i, tx_q.size());
            end else begin
                checks++;
                if (tx_q[0] !== ve[i]) begin
                    errors++; $display("FAIL dir%0d_data got=%02h want=%02h", i, tx_q[0], ve[i]);
                end
            end
            repeat (5) @(posedge clk);
            checks++;
            if (tx_q.size() != 1) begin
                errors++; $display("FAIL dir%0d_start_count got=%0d want=1", i, tx_q.size());
            end
            tx_ack();
        end
    endtask

    task automatic test_random();
        logic [7:0] ops[8];
        logic [7:0] a, b, op, exp;
        bit ok;
        ops = '{8'h20, 8'h22, 8'h24, 8'h25, 8'h26, 8'h27, 8'h03, 8'h02};
        for (int i = 0; i < 24; i++) begin
            a  = 8'($urandom_range(0, 255));
            b  = 8'($urandom_range(0, 255));
            op = ($urandom_range(0, 3) != 0) ? ops[$urandom_range(0, 7)]
                                              : 8'($urandom_range(0, 255));
            exp = ref_alu(a, b, op);
            tx_q.delete();
            send_triple(a, b, op);
            wait_tx(1, ok);
            checks++;
            if (!ok) begin
                errors++; $display("FAIL rnd%0d_timeout got=%0d starts want=1", i, tx_q.size());
            end else begin
                checks++;
                if (tx_q[0] !== exp) begin
                    errors++;
                    $display("FAIL rnd%0d_data a=%02h b=%02h op=%02h got=%02h want=%02h",
                             i, a, b, op, tx_q[0], exp);
                end
            end
            tx_ack();
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        tx_q.delete();
        send_triple(8'h06, 8'h05, 8'h20);
        wait_tx(1, ok);
        checks++;
        if (!ok) begin
            errors++; $display("FAIL b2b_first_timeout got=%0d want=1", tx_q.size());
        end
        send_triple(8'h03, 8'h05, 8'h22);
        repeat (10) @(posedge clk);
        @(negedge clk);
        checks++;
        if (tx_q.size() != 1) begin
            errors++; $display("FAIL b2b_early_start got=%0d want=1", tx_q.size());
        end
        checks++;
        if (tx_data !== 8'h0B) begin
            errors++; $display("FAIL b2b_hold_data got=%02h want=0b", tx_data);
        end
        tx_ack();
        wait_tx(2, ok);
        checks++;
        if (!ok) begin
            errors++; $display("FAIL b2b_second_timeout got=%0d want=2", tx_q.size());
        end else begin
            checks++;
            if (tx_q[0] !== 8'h0B || tx_q[1] !== 8'hFE) begin
                errors++; $display("FAIL b2b_data got=%02h,%02h want=0b,fe", tx_q[0], tx_q[1]);
            end
        end
        repeat (8) @(posedge clk);
        checks++;
        if (tx_q.size() != 2) begin
            errors++; $display("FAIL b2b_start_count got=%0d want=2", tx_q.size());
        end
        tx_ack();
    endtask

    task automatic test_reset_mid();
        bit ok;
        tx_q.delete();
        send_byte(8'h55, 1);
        send_byte(8'h66, 1);
        @(posedge clk); #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        send_byte(8'h02, 10);
        send_byte(8'h03, 1);
        send_byte(8'h20, 1);
        wait_tx(1, ok);
        checks++;
        if (!ok) begin
            errors++; $display("FAIL rstmid_timeout got=%0d want=1", tx_q.size());
        end else begin
            checks++;
            if (tx_q[0] !== 8'h05) begin
                errors++; $display("FAIL rstmid_data got=%02h want=05", tx_q[0]);
            end
        end
        repeat (5) @(posedge clk);
        checks++;
        if (tx_q.size() != 1) begin
            errors++; $display("FAIL rstmid_start_count got=%0d want=1", tx_q.size());
        end
        tx_ack();
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        rst     = 1'b0;
        rx_data = 8'h00;
        rx_done = 1'b0;
        tx_done = 1'b0;
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
